// File: rtl/display_pkg.sv
// Shared definitions for the display scan decoder: glyph masks, FSM encoding, defaults.
// Glyph masks are ordered {A,B,C,D,E,F,G}, active-high.
package display_pkg;

  localparam int DEFAULT_SETTLE_CYCLES  = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1111011;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b0011111;
  localparam logic [6:0] GLYPH_C = 7'b1001110;
  localparam logic [6:0] GLYPH_D = 7'b0111101;
  localparam logic [6:0] GLYPH_E = 7'b1001111;
  localparam logic [6:0] GLYPH_F = 7'b1000111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/display_scan_decoder_if.sv
// Scanned-display input lines and captured-digit outputs of the decoder.
// master drives the display lines, slave is the decoder.
interface display_scan_decoder_if;
  logic [3:0]  ds_en_n;
  logic [6:0]  seg_in;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        seg_err;
  logic        frame_done;

  modport master (
    output ds_en_n, seg_in,
    input  digits, digit_valid, seg_err, frame_done
  );

  modport slave (
    input  ds_en_n, seg_in,
    output digits, digit_valid, seg_err, frame_done
  );
endinterface

// File: rtl/display_scan_decoder_seg7_to_hex.sv
// Combinational 7-segment mask to hex value lookup with a legal-glyph flag.
// Also reused by the display driver bench.
module seg7_to_hex
  import display_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       legal
);
  always_comb begin
    hex   = 4'h0;
    legal = 1'b1;
    case (seg)
      GLYPH_0: hex = 4'h0;
      GLYPH_1: hex = 4'h1;
      GLYPH_2: hex = 4'h2;
      GLYPH_3: hex = 4'h3;
      GLYPH_4: hex = 4'h4;
      GLYPH_5: hex = 4'h5;
      GLYPH_6: hex = 4'h6;
      GLYPH_7: hex = 4'h7;
      GLYPH_8: hex = 4'h8;
      GLYPH_9: hex = 4'h9;
      GLYPH_A: hex = 4'hA;
      GLYPH_B: hex = 4'hB;
      GLYPH_C: hex = 4'hC;
      GLYPH_D: hex = 4'hD;
      GLYPH_E: hex = 4'hE;
      GLYPH_F: hex = 4'hF;
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/display_scan_decoder.sv
// Recovers hex digits from a multiplexed 7-segment scan: sync, settle, capture once per dwell.
// Capture lands 2 + SETTLE_CYCLES cycles after an input becomes stable; no backpressure.
module display_scan_decoder
  import display_pkg::*;
#(
  parameter int SETTLE_CYCLES  = DEFAULT_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  display_scan_decoder_if.slave  bus
);
  localparam logic [7:0]  SETTLE_LIM = 8'(SETTLE_CYCLES);
  localparam logic [19:0] TMO_LIM    = 20'(TIMEOUT_CYCLES);

  logic [3:0]  en_s1, en_s2, en_prev;
  logic [6:0]  seg_s1, seg_s2, seg_prev;
  logic [7:0]  stable_cnt;
  logic [19:0] tmo_cnt;
  state_t      state;
  logic [15:0] digits_q, digits_n;
  logic [3:0]  valid_q, valid_n, frame_q, frame_n;
  logic        seg_err_q, frame_done_q;

  logic        en_legal, changed, capture, cap_ok, cap_bad, timed_out, glyph_ok;
  logic [7:0]  run_len;
  logic [19:0] tmo_inc, tmo_next;
  logic [6:0]  seg_eff;
  logic [3:0]  hex;

  assign seg_eff  = SEG_ACTIVE_LOW ? ~seg_s2 : seg_s2;
  assign en_legal = $onehot(~en_s2);
  assign changed  = {en_s2, seg_s2} != {en_prev, seg_prev};
  // run_len counts the cycles the current synchronized value has been present, this one included
  assign run_len  = changed ? 8'd1 : ((stable_cnt == 8'hFF) ? 8'hFF : stable_cnt + 8'd1);
  assign capture  = en_legal && (run_len == SETTLE_LIM) && ((state != ST_HOLD) || changed);
  assign cap_ok   = capture && glyph_ok;
  assign cap_bad  = capture && !glyph_ok;

  assign tmo_inc   = (tmo_cnt == TMO_LIM) ? tmo_cnt : tmo_cnt + 20'd1;
  assign tmo_next  = cap_ok ? 20'd0 : tmo_inc;
  assign timed_out = !cap_ok && (tmo_inc == TMO_LIM);

  seg7_to_hex u_dec (
    .seg   (seg_eff),
    .hex   (hex),
    .legal (glyph_ok)
  );

  always_comb begin
    digits_n = digits_q;
    valid_n  = valid_q;
    frame_n  = (frame_q == 4'hF) ? 4'h0 : frame_q;
    if (cap_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (!en_s2[i]) begin
          digits_n[4*i +: 4] = hex;
          valid_n[i]         = 1'b1;
          frame_n[i]         = 1'b1;
        end
      end
    end
    if (timed_out) begin
      valid_n = 4'h0;
      frame_n = 4'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_s1        <= 4'hF;
      en_s2        <= 4'hF;
      en_prev      <= 4'hF;
      seg_s1       <= 7'h00;
      seg_s2       <= 7'h00;
      seg_prev     <= 7'h00;
      stable_cnt   <= 8'd0;
      tmo_cnt      <= 20'd0;
      state        <= ST_IDLE;
      digits_q     <= 16'h0000;
      valid_q      <= 4'h0;
      frame_q      <= 4'h0;
      seg_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      en_s1        <= bus.ds_en_n;
      en_s2        <= en_s1;
      en_prev      <= en_s2;
      seg_s1       <= bus.seg_in;
      seg_s2       <= seg_s1;
      seg_prev     <= seg_s2;
      stable_cnt   <= run_len;
      tmo_cnt      <= tmo_next;
      digits_q     <= digits_n;
      valid_q      <= valid_n;
      frame_q      <= frame_n;
      seg_err_q    <= cap_bad;
      frame_done_q <= (frame_q == 4'hF);
      if (!en_legal)
        state <= ST_IDLE;
      else if (capture)
        state <= ST_HOLD;
      else if (state == ST_HOLD && !changed)
        state <= ST_HOLD;
      else
        state <= ST_SETTLE;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.seg_err     = seg_err_q;
  assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_display_scan_decoder.sv
// Bench for display_scan_decoder: directed scenarios plus randomized scan against a
// history-based reference model (capture when a legal value has been stable exactly SETTLE cycles).
module tb_display_scan_decoder;
  localparam int SETTLE = 4;
  localparam int TMO    = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_scan_decoder_if bus();

  display_scan_decoder #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [6:0] glyph_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Reference model: raw input history per edge, synchronized view is two edges old
  logic [10:0] hist [$];
  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_frame;
  logic        m_seg_err, m_frame_done, m_cap_ok, m_done;
  logic [10:0] mv;
  int          m_tmo, mrun, mg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < 16; i++) hist.push_back({4'hF, 7'h00});
      m_digits = '0; m_valid = '0; m_frame = '0;
      m_seg_err = 1'b0; m_frame_done = 1'b0; m_tmo = 0;
    end else begin
      hist.push_back({bus.ds_en_n, bus.seg_in});
      void'(hist.pop_front());
      mv = hist[hist.size()-3];
      mrun = 0; m_done = 1'b0;
      for (int k = hist.size()-3; k >= 0; k--) begin
        if (!m_done && hist[k] == mv) mrun++;
        else m_done = 1'b1;
      end
      m_seg_err    = 1'b0;
      m_frame_done = (m_frame == 4'hF);
      if (m_frame_done) m_frame = 4'h0;
      m_cap_ok = 1'b0;
      if ($countones(~mv[10:7]) == 1 && mrun == SETTLE) begin
        mg = -1;
        for (int g = 0; g < 16; g++) if (glyph_tab[g] == mv[6:0]) mg = g;
        if (mg < 0) m_seg_err = 1'b1;
        else begin
          for (int p = 0; p < 4; p++) begin
            if (!mv[7+p]) begin
              m_digits[4*p +: 4] = mg[3:0];
              m_valid[p] = 1'b1;
              m_frame[p] = 1'b1;
              m_cap_ok   = 1'b1;
            end
          end
        end
      end
      if (m_cap_ok) m_tmo = 0;
      else begin
        if (m_tmo < TMO) m_tmo++;
        if (m_tmo == TMO) begin m_valid = 4'h0; m_frame = 4'h0; end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.ds_en_n = 4'hF;
    bus.seg_in  = 7'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic scan_frame(input logic [15:0] hexes, output int pulses, output int last_edge);
    logic [3:0] h;
    pulses = 0; last_edge = -1;
    for (int d = 0; d < 4; d++) begin
      h = hexes[15-4*d -: 4];
      bus.ds_en_n = ~(4'b1000 >> d);
      bus.seg_in  = glyph_tab[h];
      for (int e = 1; e <= 8; e++) begin
        tick();
        if (bus.frame_done) begin pulses++; last_edge = d*8 + e; end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (bus.digits !== 16'h0000) begin tests_failed++; $display("FAIL reset_digits got %h want 0000", bus.digits); end
    tests_run++; if (bus.digit_valid !== 4'h0) begin tests_failed++; $display("FAIL reset_valid got %b want 0000", bus.digit_valid); end
    tests_run++; if (bus.seg_err !== 1'b0) begin tests_failed++; $display("FAIL reset_seg_err got %b want 0", bus.seg_err); end
    tests_run++; if (bus.frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
    tick();
    tests_run++; if ({bus.seg_err, bus.frame_done} !== 2'b00) begin tests_failed++; $display("FAIL release_pulses got %b want 00", {bus.seg_err, bus.frame_done}); end
  endtask

  task automatic test_single_digit();
    int errs = 0;
    do_reset();
    bus.ds_en_n = 4'b1011;
    bus.seg_in  = glyph_tab[2];
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (bus.seg_err) errs++;
      if (e == 5) begin
        tests_run++; if (bus.digit_valid !== 4'b0000) begin tests_failed++; $display("FAIL single_early got %b want 0000", bus.digit_valid); end
      end
      if (e == 6) begin
        tests_run++; if (bus.digits[11:8] !== 4'h2) begin tests_failed++; $display("FAIL single_digit got %h want 2", bus.digits[11:8]); end
        tests_run++; if (bus.digit_valid !== 4'b0100) begin tests_failed++; $display("FAIL single_valid got %b want 0100", bus.digit_valid); end
      end
    end
    tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL single_seg_err got %0d want 0", errs); end
  endtask

  task automatic test_frame();
    int pulses, last_edge;
    do_reset();
    scan_frame(16'h7A0F, pulses, last_edge);
    tests_run++; if (bus.digits !== 16'h7A0F) begin tests_failed++; $display("FAIL frame_digits got %h want 7a0f", bus.digits); end
    tests_run++; if (bus.digit_valid !== 4'hF) begin tests_failed++; $display("FAIL frame_valid got %b want 1111", bus.digit_valid); end
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL frame_pulses got %0d want 1", pulses); end
    tests_run++; if (last_edge !== 31) begin tests_failed++; $display("FAIL frame_pulse_edge got %0d want 31", last_edge); end
  endtask

  task automatic test_illegal_enable();
    bus.ds_en_n = 4'b0011;
    bus.seg_in  = glyph_tab[1];
    for (int e = 0; e < 20; e++) begin
      tick();
      tests_run++;
      if (bus.digits !== 16'h7A0F || bus.digit_valid !== 4'hF || bus.seg_err || bus.frame_done) begin
        tests_failed++;
        $display("FAIL illegal_en cycle %0d got %h/%b/%b/%b want 7a0f/1111/0/0", e, bus.digits, bus.digit_valid, bus.seg_err, bus.frame_done);
      end
    end
  endtask

  task automatic test_bad_glyph();
    int errs = 0;
    do_reset();
    bus.ds_en_n = 4'b1101;
    bus.seg_in  = glyph_tab[5];
    repeat (8) tick();
    tests_run++; if (bus.digits !== 16'h0050) begin tests_failed++; $display("FAIL badg_pre got %h want 0050", bus.digits); end
    bus.seg_in = 7'b1010101;
    repeat (10) begin tick(); if (bus.seg_err) errs++; end
    tests_run++; if (errs !== 1) begin tests_failed++; $display("FAIL badg_pulses got %0d want 1", errs); end
    tests_run++; if (bus.digits !== 16'h0050) begin tests_failed++; $display("FAIL badg_digits got %h want 0050", bus.digits); end
    tests_run++; if (bus.digit_valid !== 4'b0010) begin tests_failed++; $display("FAIL badg_valid got %b want 0010", bus.digit_valid); end
  endtask

  task automatic test_toggle();
    do_reset();
    bus.ds_en_n = 4'b0111;
    for (int t = 0; t < 20; t++) begin
      bus.seg_in = glyph_tab[(t % 2 == 0) ? 1 : 8];
      repeat (3) begin
        tick();
        tests_run++;
        if (bus.digit_valid !== 4'h0) begin tests_failed++; $display("FAIL toggle_valid got %b want 0000", bus.digit_valid); end
      end
    end
    bus.ds_en_n = 4'hF;
  endtask

  task automatic test_timeout_and_reset();
    int pulses, last_edge;
    do_reset();
    scan_frame(16'h7A0F, pulses, last_edge);
    bus.ds_en_n = 4'hF;
    repeat (50) tick();
    tests_run++; if (bus.digit_valid !== 4'hF) begin tests_failed++; $display("FAIL tmo_early got %b want 1111", bus.digit_valid); end
    repeat (60) tick();
    tests_run++; if (bus.digit_valid !== 4'h0) begin tests_failed++; $display("FAIL tmo_valid got %b want 0000", bus.digit_valid); end
    tests_run++; if (bus.digits !== 16'h7A0F) begin tests_failed++; $display("FAIL tmo_digits got %h want 7a0f", bus.digits); end
    bus.ds_en_n = 4'b0111;
    bus.seg_in  = glyph_tab[3];
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if ({bus.digits, bus.digit_valid, bus.seg_err, bus.frame_done} !== 22'h0) begin
      tests_failed++; $display("FAIL async_reset got %h/%b want 0000/0000", bus.digits, bus.digit_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 1) begin
        tests_run++; if ({bus.seg_err, bus.frame_done} !== 2'b00) begin tests_failed++; $display("FAIL post_rst_pulse got %b want 00", {bus.seg_err, bus.frame_done}); end
      end
      if (e == 5) begin
        tests_run++; if (bus.digit_valid !== 4'h0) begin tests_failed++; $display("FAIL post_rst_early got %b want 0000", bus.digit_valid); end
      end
    end
    tests_run++; if (bus.digits !== 16'h3000 || bus.digit_valid !== 4'b1000) begin
      tests_failed++; $display("FAIL post_rst_capture got %h/%b want 3000/1000", bus.digits, bus.digit_valid); end
  endtask

  task automatic test_random();
    int cycles = 0;
    int r, hold;
    do_reset();
    while (cycles < 2000) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      bus.ds_en_n = ~(4'b0001 << $urandom_range(0, 3));
      else if (r == 7) bus.ds_en_n = 4'hF;
      else             bus.ds_en_n = 4'($urandom);
      bus.seg_in = ($urandom_range(0, 4) != 0) ? glyph_tab[$urandom_range(0, 15)] : 7'($urandom);
      hold = ($urandom_range(0, 19) == 0) ? 120 : $urandom_range(1, 9);
      repeat (hold) begin
        tick();
        cycles++;
        tests_run++; if (bus.digits !== m_digits) begin tests_failed++; $display("FAIL rnd_digits cyc %0d got %h want %h", cycles, bus.digits, m_digits); end
        tests_run++; if (bus.digit_valid !== m_valid) begin tests_failed++; $display("FAIL rnd_valid cyc %0d got %b want %b", cycles, bus.digit_valid, m_valid); end
        tests_run++; if (bus.seg_err !== m_seg_err) begin tests_failed++; $display("FAIL rnd_seg_err cyc %0d got %b want %b", cycles, bus.seg_err, m_seg_err); end
        tests_run++; if (bus.frame_done !== m_frame_done) begin tests_failed++; $display("FAIL rnd_frame_done cyc %0d got %b want %b", cycles, bus.frame_done, m_frame_done); end
      end
    end
  endtask

  initial begin
    bus.ds_en_n = 4'hF;
    bus.seg_in  = 7'h00;
    test_reset();
    test_single_digit();
    test_frame();
    test_illegal_enable();
    test_bad_glyph();
    test_toggle();
    test_timeout_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
